barrel_unrotator: RTL and testbench

Sequential inverse of the multi-function barrel rotator: takes a word the rotator produced, plus the rotate amount and direction select that produced it, and iteratively rotates it back to recover the original operand. It moves one bit position per clock and uses a valid/ready handshake on both sides. It sits on the receive side of any datapath that passes rotated words with their shift metadata.

---
 rtl/barrel_pkg.sv | 16 +
 rtl/barrel_unrotator_rotate_step.sv | 23 ++
 rtl/barrel_unrotator.sv | 104 ++++++++++
 tb/tb_barrel_unrotator.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// Shared types and constants for the barrel rotator family.
package barrel_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    // Forward direction encoding, matching the rotator's s0 select
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } unrot_state_t;

endpackage

// File: rtl/barrel_unrotator_rotate_step.sv
// rotate_step: combinational rotate of a word by one or two positions.
module rotate_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic             right,
    input  logic             two,
    output logic [WIDTH-1:0] q_c
);

    // Select one of the four single/double, left/right rotations
    always_comb begin
        q_c = d;
        unique case ({right, two})
            2'b10:   q_c = {d[0],         d[WIDTH-1:1]};
            2'b11:   q_c = {d[1:0],       d[WIDTH-1:2]};
            2'b00:   q_c = {d[WIDTH-2:0], d[WIDTH-1]};
            2'b01:   q_c = {d[WIDTH-3:0], d[WIDTH-1:WIDTH-2]};
            default: q_c = d;
        endcase
    end

endmodule

// File: rtl/barrel_unrotator.sv
// barrel_unrotator: iteratively undoes a barrel rotation, one bit per clock
// (two per clock when UNROTATE_FAST_EN is defined), with valid/ready on both
// sides. a_out is the working data register itself.
module barrel_unrotator
    import barrel_pkg::*;
#(
    parameter  int unsigned WIDTH = WIDTH_DEFAULT,
    localparam int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] b_in,
    input  logic [AMT_W-1:0] amt,
    input  logic             s0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_out,
    output logic             busy
);

    unrot_state_t     state;
    logic [WIDTH-1:0] data;
    logic [AMT_W-1:0] cnt;
    logic             dir;

    logic             two_c;
    logic [AMT_W-1:0] step_c;
    logic             last_c;
    logic [WIDTH-1:0] rot_c;

    // Step size: double steps only while at least two positions remain
`ifdef UNROTATE_FAST_EN
    assign two_c = (cnt >= AMT_W'(2));
`else
    assign two_c = 1'b0;
`endif

    assign step_c   = two_c ? AMT_W'(2) : AMT_W'(1);
    assign last_c   = (cnt <= step_c);
    assign in_ready = (state == IDLE);
    assign a_out    = data;

    // Undo the forward rotation: a left-rotated word turns back right
    rotate_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .d     (data),
        .right (dir == DIR_LEFT),
        .two   (two_c),
        .q_c   (rot_c)
    );

    // Job FSM with datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            data      <= '0;
            cnt       <= '0;
            dir       <= DIR_RIGHT;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        data <= b_in;
                        cnt  <= amt;
                        dir  <= s0;
                        busy <= 1'b1;
                        if (amt == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ROT;
                        end
                    end
                end
                ROT: begin
                    data <= rot_c;
                    cnt  <= cnt - step_c;
                    if (last_c) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrel_unrotator.sv
// Directed and randomized checks for barrel_unrotator (WIDTH = 8).
// Honours UNROTATE_FAST_EN for the expected latency.
module tb_barrel_unrotator;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] b_in;
    logic [2:0] amt;
    logic       s0;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] a_out;
    logic       busy;

    int nvec  = 0;
    int nfail = 0;

    barrel_unrotator #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .b_in      (b_in),
        .amt       (amt),
        .s0        (s0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic [2:0] amt;
        logic       s0;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] a);
        int n;
        n = int'(a);
`ifdef UNROTATE_FAST_EN
        n = (n + 1) / 2;
`endif
        return n;
    endfunction

    // Independent reference: s0=1 was a left rotate, so rotate right to undo
    function automatic logic [7:0] ref_unrot(input logic [7:0] b, input logic [2:0] a, input logic s);
        logic [15:0] dbl;
        logic [15:0] sh;
        dbl = {b, b};
        if (s) begin
            sh = dbl >> a;
            return sh[7:0];
        end else begin
            sh = dbl << a;
            return sh[15:8];
        end
    endfunction

    // Accept a job, wait for out_valid, check latency/result; drain if out_ready
    task automatic run_job(input string name, input logic [7:0] b, input logic [2:0] a,
                           input logic s, input logic [7:0] req);
        int edges;
        @(negedge clk);
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        b_in     = b;
        amt      = a;
        s0       = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({name, "_busy"}, 32'(busy), 32'd1);
        edges = 0;
        while (!out_valid && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({name, "_latency"}, 32'(edges), 32'(exp_lat(a)));
        check({name, "_a_out"}, 32'(a_out), 32'(req));
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({name, "_drained"}, 32'({out_valid, busy, in_ready}), 32'b001);
        end
    endtask

    vec_t vecs[8];

    initial begin
        int drains;
        int accepts;
        logic [7:0] expq[$];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        b_in      = '0;
        amt       = '0;
        s0        = 1'b0;
        out_ready = 1'b1;

        // Hand-computed vectors: s0=1 undo by rotating right, s0=0 by rotating left
        vecs[0] = '{8'b01011010, 3'd3, 1'b1, 8'b01001011};
        vecs[1] = '{8'b01101001, 3'd3, 1'b0, 8'b01001011};
        vecs[2] = '{8'h48,       3'd0, 1'b1, 8'h48};
        vecs[3] = '{8'b10010000, 3'd1, 1'b1, 8'b01001000};
        vecs[4] = '{8'h96,       3'd7, 1'b0, 8'h4B};
        vecs[5] = '{8'h01,       3'd4, 1'b1, 8'h10};
        vecs[6] = '{8'h80,       3'd5, 1'b0, 8'h10};
        vecs[7] = '{8'hC3,       3'd2, 1'b0, 8'h0F};

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_a_out",     32'(a_out),     32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // Table-driven jobs
        for (int i = 0; i < 8; i++) begin
            run_job($sformatf("vec%0d", i), vecs[i].b, vecs[i].amt, vecs[i].s0, vecs[i].exp);
        end

        // Backpressure: hold out_ready low in DONE while in_valid pulses are ignored
        out_ready = 1'b0;
        run_job("bp", 8'b01011010, 3'd3, 1'b1, 8'b01001011);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = (c % 2) == 0;
            b_in     = 8'hFF;
            amt      = 3'd1;
            s0       = 1'b0;
            check($sformatf("bp_hold%0d", c), 32'({out_valid, in_ready, a_out}), {22'd0, 2'b10, 8'b01001011});
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", 32'({out_valid, busy, in_ready}), 32'b001);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_ghost_job", 32'({out_valid, busy}), 32'd0);

        // Reset two edges into an amt=7 job
        @(negedge clk);
        in_valid = 1'b1;
        b_in     = 8'h96;
        amt      = 3'd7;
        s0       = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_state", 32'({out_valid, busy, a_out}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job("post_rst", 8'h96, 3'd7, 1'b0, 8'h4B);

        // Back-to-back random jobs with out_ready held high
        drains  = 0;
        accepts = 0;
        out_ready = 1'b1;
        fork
            begin
                for (int j = 0; j < 100; j++) begin
                    int guard;
                    logic [7:0] rb;
                    logic [2:0] ra;
                    logic       rs;
                    guard = 0;
                    @(negedge clk);
                    while (!in_ready && guard < 50) begin
                        @(negedge clk);
                        guard++;
                    end
                    rb = 8'($urandom);
                    ra = 3'($urandom_range(0, 7));
                    rs = 1'($urandom_range(0, 1));
                    b_in     = rb;
                    amt      = ra;
                    s0       = rs;
                    in_valid = 1'b1;
                    expq.push_back(ref_unrot(rb, ra, rs));
                    @(posedge clk);
                    accepts++;
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                int cyc;
                cyc = 0;
                while (drains < 100 && cyc < 5000) begin
                    @(negedge clk);
                    cyc++;
                    if (out_valid && out_ready) begin
                        if (expq.size() == 0) begin
                            check("b2b_spurious_out", 32'd1, 32'd0);
                        end else begin
                            check($sformatf("b2b_job%0d", drains), 32'(a_out), 32'(expq.pop_front()));
                        end
                        drains++;
                    end
                end
                check("b2b_drain_count", 32'(drains), 32'd100);
            end
        join
        repeat (10) @(negedge clk);
        check("b2b_accept_eq_drain", 32'(accepts), 32'(drains));
        check("b2b_queue_empty", 32'(expq.size()), 32'd0);
        check("b2b_idle", 32'({out_valid, busy, in_ready}), 32'b001);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
